dm_store_buffer: RTL

//  M-stage store buffer, directly downstream of the store-data lane-replication logic. Accepts replicated

---
 rtl/dm_store_buffer_pkg.sv | 81 ++++++++
 rtl/dm_sb_fifo.sv | 100 ++++++++++
 rtl/dm_store_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dm_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dm_store_buffer_pkg
// Shared definitions for the M-stage store buffer:
//   - store opcodes (instruction-type encodings seen on M_instrType)
//   - AdES exception code and byte-enable constants
//   - drain FSM state type, queue entry layout, store decode result
//   - helpers: store decode (byte enables + alignment) and lane merge
// Optional feature macro used by the buffer: DM_WB_MERGE_EN (store merging).
// -----------------------------------------------------------------------------
package dm_store_buffer_pkg;

    // Instruction-type encodings for the three store flavours
    localparam logic [9:0] INSTR_SB = 10'd40;
    localparam logic [9:0] INSTR_SH = 10'd41;
    localparam logic [9:0] INSTR_SW = 10'd43;

    // Address-error-on-store exception code
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Byte-enable patterns; bit i = byte lane i
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } sb_entry_t;

    typedef struct packed {
        logic       is_store;
        logic       misaligned;
        logic [3:0] byteen;
    } st_decode_t;

    // Classify the M instruction and derive its byte enables from the low address bits
    function automatic st_decode_t decode_store(input logic [9:0] instr_type,
                                                input logic [1:0] offset);
        st_decode_t d;
        d = '0;
        case (instr_type)
            INSTR_SW: begin
                d.is_store   = 1'b1;
                d.byteen     = BE_WORD;
                d.misaligned = (offset != 2'b00);
            end
            INSTR_SH: begin
                d.is_store   = 1'b1;
                d.byteen     = offset[1] ? BE_HALF_HI : BE_HALF_LO;
                d.misaligned = offset[0];
            end
            INSTR_SB: begin
                d.is_store   = 1'b1;
                d.byteen     = BE_BYTE0 << offset;
                d.misaligned = 1'b0;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    // Overwrite the lanes enabled in new_be with new_data, keep the rest of old_data
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  new_be);
        logic [31:0] r;
        r = old_data;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = new_be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_sb_fifo.sv
// -----------------------------------------------------------------------------
// dm_sb_fifo
// Synchronous FIFO of store-buffer entries {waddr, wdata, byteen}.
// Ports:
//   clk, reset      clock, synchronous active-high reset (discards contents)
//   push / wr_entry allocate wr_entry at the tail
//   merge           fold wr_entry into the newest entry (byteen OR, lane overwrite)
//   pop             retire the head entry
//   cmp_waddr       word address compared against every occupied slot
//   head_entry      oldest entry
//   hit_vec         per-slot "occupied and word address matches cmp_waddr"
//   tail_hit        newest entry exists and matches cmp_waddr (DM_WB_MERGE_EN only)
//   count/full/empty occupancy
// Optional feature macro: DM_WB_MERGE_EN adds the tail_hit port.
// -----------------------------------------------------------------------------
module dm_sb_fifo
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             merge,
    input  sb_entry_t        wr_entry,
    input  logic [29:0]      cmp_waddr,
    output sb_entry_t        head_entry,
    output logic [DEPTH-1:0] hit_vec,
`ifdef DM_WB_MERGE_EN
    output logic             tail_hit,
`endif
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = CNT_W - 1;

    sb_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] tail_ptr_s;
    logic [PTR_W-1:0] offs_s;
    logic [CNT_W-1:0] count_r;
    logic [DEPTH-1:0] valid_s;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: allocate at the write pointer, or fold a merge into the newest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end else if (merge) begin
            mem_r[tail_ptr_s].byteen <= mem_r[tail_ptr_s].byteen | wr_entry.byteen;
            mem_r[tail_ptr_s].wdata  <= merge_lanes(mem_r[tail_ptr_s].wdata,
                                                    wr_entry.wdata, wr_entry.byteen);
        end
    end

    // Occupied-slot window and per-slot address compare; the head stays occupied until popped
    always_comb begin
        tail_ptr_s = wr_ptr_r - PTR_W'(1);
        offs_s     = '0;
        valid_s    = '0;
        hit_vec    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs_s     = PTR_W'(i) - rd_ptr_r;
            valid_s[i] = ({1'b0, offs_s} < count_r);
            hit_vec[i] = valid_s[i] && (mem_r[i].waddr == cmp_waddr);
        end
    end

`ifdef DM_WB_MERGE_EN
    assign tail_hit   = (count_r != '0) && (mem_r[tail_ptr_s].waddr == cmp_waddr);
`endif
    assign head_entry = mem_r[rd_ptr_r];
    assign count      = count_r;
    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == '0);

endmodule

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
// M-stage store buffer: decodes byte enables and store alignment, queues
// aligned committed stores and drains them to the data bus with req/ack.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   M_valid/M_intReq  live M instruction / exception kills it this cycle
//   M_instrType       store opcode (INSTR_SW/SH/SB), anything else is a non-store
//   M_isLoad, M_addr  load flag and byte address of the M access
//   M_realWD          lane-replicated store data, queued unmodified
//   stall_o           queue full for a store, or load hits a queued word
//   adES_o/excCode_o  misaligned store and its exception code
//   bus_req/addr/wdata/byteen, bus_ack   write handshake, head entry on the bus
//   empty_o           nothing queued and no write in flight
// Optional feature macro: DM_WB_MERGE_EN (merge stores into the tail entry).
// -----------------------------------------------------------------------------
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_valid,
    input  logic        M_intReq,
    input  logic [9:0]  M_instrType,
    input  logic        M_isLoad,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_realWD,
    output logic        stall_o,
    output logic        adES_o,
    output logic [4:0]  excCode_o,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack,
    output logic        empty_o
);

    st_decode_t       dec_s;
    drain_state_e     state_r;
    drain_state_e     state_n;
    sb_entry_t        wr_entry_s;
    sb_entry_t        head_s;
    logic [DEPTH-1:0] hit_vec_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             store_ok_s;
    logic             merge_ok_s;
    logic             full_stall_s;
    logic             load_haz_s;
    logic             stall_s;
    logic             push_s;
    logic             merge_s;
    logic             pop_s;
    logic             ades_s;
`ifdef DM_WB_MERGE_EN
    logic             tail_hit_s;
`endif

    assign dec_s      = decode_store(M_instrType, M_addr[1:0]);
    assign wr_entry_s = '{waddr: M_addr[31:2], wdata: M_realWD, byteen: dec_s.byteen};

    // Store qualification, stall sources and queue controls
    always_comb begin
        ades_s     = M_valid & dec_s.is_store & dec_s.misaligned;
        store_ok_s = M_valid & dec_s.is_store & ~dec_s.misaligned & ~M_intReq;
`ifdef DM_WB_MERGE_EN
        // The head being written on the bus must stay stable, so it never absorbs a merge
        merge_ok_s = store_ok_s & tail_hit_s
                   & ~((count_s == CNT_W'(1)) & (state_r == DRAIN_REQ));
`else
        merge_ok_s = 1'b0;
`endif
        // Registered full only: a pop this cycle does not lift the stall until next cycle
        full_stall_s = full_s & M_valid & dec_s.is_store & ~merge_ok_s;
        load_haz_s   = M_valid & M_isLoad & ~M_intReq & (|hit_vec_s);
        stall_s      = full_stall_s | load_haz_s;
        push_s       = store_ok_s & ~merge_ok_s & ~full_s & ~stall_s;
        merge_s      = merge_ok_s & ~stall_s;
        pop_s        = (state_r == DRAIN_REQ) & bus_ack;
    end

    dm_sb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .pop        (pop_s),
        .merge      (merge_s),
        .wr_entry   (wr_entry_s),
        .cmp_waddr  (M_addr[31:2]),
        .head_entry (head_s),
        .hit_vec    (hit_vec_s),
`ifdef DM_WB_MERGE_EN
        .tail_hit   (tail_hit_s),
`endif
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= DRAIN_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Drain FSM next state; stays in REQ across acks while entries remain (no bubble)
    always_comb begin
        state_n = state_r;
        case (state_r)
            DRAIN_IDLE: begin
                if (count_s != '0) state_n = DRAIN_REQ;
                else               state_n = DRAIN_IDLE;
            end
            DRAIN_REQ: begin
                if (bus_ack) begin
                    if (count_s != CNT_W'(1)) state_n = DRAIN_REQ;
                    else                      state_n = DRAIN_IDLE;
                end else begin
                    state_n = DRAIN_REQ;
                end
            end
            default: state_n = DRAIN_IDLE;
        endcase
    end

    assign stall_o    = stall_s;
    assign adES_o     = ades_s;
    assign excCode_o  = ades_s ? EXC_ADES : 5'd0;
    assign bus_req    = (state_r == DRAIN_REQ);
    assign bus_addr   = {head_s.waddr, 2'b00};
    assign bus_wdata  = head_s.wdata;
    assign bus_byteen = head_s.byteen;
    assign empty_o    = empty_s & (state_r == DRAIN_IDLE);

endmodule
